// File: rtl/centroid_div_sched.sv
// K-means centroid update: one restoring divider time-shared over all jobs.
// Define DIV_ROUND_EN for round-to-nearest quotients (default truncates).
module centroid_div_sched #(
    parameter int K     = 16,
    parameter int SUM_W = 20,
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [K-1:0]     cluster_en,
    output logic             busy,
    output logic             done,
    output logic [3:0]       rd_idx,
    output logic [1:0]       rd_comp,
    input  logic [SUM_W-1:0] sum_rd_data,
    input  logic [CNT_W-1:0] cnt_rd_data,
    output logic             cen_we,
    output logic [3:0]       cen_idx,
    output logic [1:0]       cen_comp,
    output logic [SUM_W-1:0] cen_data
);

    localparam int BW = $clog2(SUM_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DIVIDE,
        S_WRITE,
        S_DONE
    } state_e;

    state_e           state_q;
    logic [15:0]      en_q;
    logic [SUM_W-1:0] q_q;
    logic [CNT_W:0]   rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic [BW-1:0]    bit_q;
    logic [3:0]       idx_q;
    logic [1:0]       comp_q;
    logic             busy_q;
    logic             done_q;
    logic             we_q;
    logic [3:0]       cidx_q;
    logic [1:0]       ccomp_q;
    logic [SUM_W-1:0] cdata_q;

    logic [CNT_W:0]   den;
    logic [CNT_W:0]   rem_sh;
    logic [CNT_W:0]   rem_d;
    logic             ge;
    logic [SUM_W-1:0] q_d;
    logic [SUM_W-1:0] res;
    logic             last;
    logic             skip;
    logic [3:0]       idx_d;
    logic [1:0]       comp_d;

    // q_q starts as the dividend and fills with quotient bits from the LSB
    always_comb begin
        den    = {1'b0, cnt_q};
        rem_sh = {rem_q[CNT_W-1:0], q_q[SUM_W-1]};
        ge     = rem_q[CNT_W] || (rem_sh >= den);
        rem_d  = ge ? (rem_sh - den) : rem_sh;
        q_d    = {q_q[SUM_W-2:0], ge};
`ifdef DIV_ROUND_EN
        res    = q_d + SUM_W'({rem_d[CNT_W-1:0], 1'b0} >= den);
`else
        res    = q_d;
`endif
        last   = (idx_q == 4'(K-1)) && (comp_q == 2'd2);
        skip   = !en_q[idx_q] || (cnt_rd_data == '0);
        idx_d  = idx_q;
        comp_d = comp_q + 2'd1;
        if (comp_q == 2'd2) begin
            idx_d  = idx_q + 4'd1;
            comp_d = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            en_q    <= '0;
            q_q     <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            comp_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            cidx_q  <= '0;
            ccomp_q <= '0;
            cdata_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        en_q    <= 16'(cluster_en);
                        idx_q   <= '0;
                        comp_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (skip) begin
                        if (last) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            idx_q  <= idx_d;
                            comp_q <= comp_d;
                        end
                    end else begin
                        q_q     <= sum_rd_data;
                        cnt_q   <= cnt_rd_data;
                        rem_q   <= '0;
                        bit_q   <= '0;
                        state_q <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    q_q   <= q_d;
                    rem_q <= rem_d;
                    bit_q <= bit_q + 1'b1;
                    if (bit_q == BW'(SUM_W-1)) begin
                        we_q    <= 1'b1;
                        cidx_q  <= idx_q;
                        ccomp_q <= comp_q;
                        cdata_q <= res;
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    we_q <= 1'b0;
                    if (last) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q   <= idx_d;
                        comp_q  <= comp_d;
                        state_q <= S_FETCH;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_idx   = idx_q;
    assign rd_comp  = comp_q;
    assign cen_we   = we_q;
    assign cen_idx  = cidx_q;
    assign cen_comp = ccomp_q;
    assign cen_data = cdata_q;

endmodule

// File: doc/centroid_div_sched.md
# centroid_div_sched

Sequencer that computes the K-means centroid update by time-sharing one restoring divider across all cluster components instead of instantiating one divider per cluster. On `start` it walks clusters 0..K-1, components R, G, B. For each job it fetches the accumulated component sum and the pixel count, divides, and writes the quotient to the centroid store. It sits between the accumulator banks and the centroid register file and is started by the top-level iteration FSM once accumulation of a pass completes.

## Interface
- `K`, default 16: number of clusters (2..16).
- `SUM_W`, default 20: width of component sums and quotients.
- `CNT_W`, default 12: width of per-cluster pixel counts (`CNT_W` ≤ `SUM_W`).
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a full update pass; sampled only in IDLE.
- `cluster_en`  in  K: per-cluster enable, sampled at start; disabled clusters are skipped.
- `busy`  out  1: pass in progress.
- `done`  out  1: one-cycle pulse at end of pass.
- `rd_idx`  out  4: cluster index being fetched.
- `rd_comp`  out  2: component being fetched (0=R, 1=G, 2=B).
- `sum_rd_data`  in  SUM_W: combinational read of sum[`rd_idx`][`rd_comp`].
- `cnt_rd_data`  in  CNT_W: combinational read of count[`rd_idx`].
- `cen_we`  out  1: centroid write strobe.
- `cen_idx`  out  4: centroid write cluster index.
- `cen_comp`  out  2: centroid write component.
- `cen_data`  out  SUM_W: quotient written.

## Operation
- States: IDLE, FETCH, DIVIDE, WRITE, DONE.
- **IDLE**
  - On `start=1`: latch `cluster_en`, set job pointer to (0, R), go to FETCH.
  - Otherwise remain in IDLE.
- **FETCH** (1 cycle)
  - `rd_idx`/`rd_comp` present the job.
  - At the clock edge, latch `sum_rd_data` and zero-extended `cnt_rd_data`.
  - If the cluster is disabled or the count is 0: no divide and no write (the old centroid is retained). Advance to the next job, or go to DONE if this was the last job.
  - Otherwise go to DIVIDE.
- **DIVIDE** (SUM_W cycles)
  - Restoring division, one quotient bit per cycle, MSB first.
  - The partial remainder register is CNT_W+1 bits.
- **WRITE** (1 cycle)
  - Assert `cen_we` with `cen_idx`, `cen_comp` and `cen_data` = quotient.
  - Advance to the next job, or go to DONE after the job (K-1, B).
- **Job order:** component increments R→G→B, then the cluster index increments and the component wraps to R.
- **DONE** (1 cycle): `done=1`, then return to IDLE.
- `start` while not in IDLE is ignored.
- `cluster_en` changes mid-pass have no effect.
- **Arithmetic:** quotient = floor(sum / count). The quotient never exceeds the sum, so no overflow is possible. The remainder is always < count.
- **Reset** (asserted at any time, including mid-divide): immediately return to IDLE, abandon the job, and write nothing further.

## Timing
- Reset values: `busy=0`, `done=0`, `cen_we=0`, `rd_idx=0`, `rd_comp=0`, `cen_idx=0`, `cen_comp=0`, `cen_data=0`.
- `busy` rises the cycle after `start` is sampled and stays high through the DONE cycle.
- `busy` is low the cycle after `done`.
- Per-job cost:
  - Divided job: SUM_W+2 cycles (22 at defaults).
  - Skipped job: 1 cycle.
- Full pass, all 3K jobs divided: 3K·(SUM_W+2)+1 cycles after `start` to `done` (1057 at defaults).
- `cen_we` is a single-cycle pulse. Write fields are valid only while `cen_we=1` and hold their values otherwise.
- Reads are combinational. `sum_rd_data`/`cnt_rd_data` must be stable before the edge ending FETCH.

## Configuration
- `DIV_ROUND_EN`
  - **Defined:** WRITE outputs round-to-nearest: quotient+1 when 2·remainder ≥ count, evaluated in the WRITE cycle with no added latency. Overflow is impossible because remainder=0 whenever the quotient is all-ones.
  - **Undefined:** truncating floor quotient.

## Test plan
- **Basic pass:**
  - Stimulus: K=2, all clusters enabled, cluster0 sums (1000, 600, 30), count 3; cluster1 sums (255, 0, 1048575), count 1.
  - Required response: writes 333, 200, 10, 255, 0, 1048575 in order.
  - Required timing: `done` exactly 133 cycles after `start`.
- **Rounding:** sum 1001, count 3 → 333 without `DIV_ROUND_EN`, 334 with it; sum 1000, count 4 → 250 in both builds.
- **Skip rules:**
  - Stimulus: cluster1 count=0, cluster2 disabled (K=4).
  - Required response: no `cen_we` for idx 1 or 2, and the pass shortens by 2·3·21 cycles versus the all-divided case.
- **Start while busy:** pulse `start` mid-pass and in the DONE cycle → no restart, exactly one `done`, write count unchanged.
- **Reset mid-divide:**
  - Stimulus: assert `reset` during cluster0 G DIVIDE.
  - Required response: all outputs return to 0 asynchronously and no further writes occur.
  - Follow-up: a new `start` after release runs a clean full pass from (0, R).
- **Max values:** sum 2^20-1, count 4095 → 256 (256 with rounding, since remainder 255 fails the 2·remainder ≥ count test); count 1 → sum is passed through unchanged.
